// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU definitions for the pipeline controller: FSM states and the
// syscall/exit constants that id_sys_exit is decoded from.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } ctrl_state_t;

  localparam logic [31:0] SYSCALL_OP = 32'h0000000c;
  localparam logic [31:0] EXIT_CODE  = 32'd10;

  // Decode helper for the ID stage: syscall with $v0 == 10 terminates the program.
  function automatic logic is_exit_syscall(input logic [31:0] instr, input logic [31:0] v0);
    return (instr == SYSCALL_OP) && (v0 == EXIT_CODE);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator between the ID instruction's sources and the EX load.
module hazard_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_wreg,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  output logic       load_use
);

  // $zero is never a real dependency, so a load into r0 cannot stall.
  assign load_use = ex_mem_read && (ex_wreg != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_wreg)) ||
                     (id_use_rt && (id_rt == ex_wreg)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/flush decisions, halt drain FSM and statistics.
// Handshake-free block; all control outputs are combinational from state and inputs.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_sys_exit,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_br_taken,
  input  logic             go,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             if_id_halt,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ctrl_state_t   cur;
  logic [DW-1:0] drain_cnt;
  logic          load_use;
  logic          do_flush;
  logic          do_stall;
  logic          start_halt;

  hazard_detect u_hazard (
    .ex_mem_read (ex_mem_read),
    .ex_wreg     (ex_wreg),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .load_use    (load_use)
  );

  // Priority in RUN: taken branch, then load-use, then exit syscall.
  assign do_flush   = (cur == ST_RUN) && ex_br_taken;
  assign do_stall   = (cur == ST_RUN) && !ex_br_taken && load_use;
  assign start_halt = (cur == ST_RUN) && !ex_br_taken && !load_use && id_sys_exit;
  assign state      = cur;

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if_id_halt  = 1'b0;
    halted      = 1'b0;
    case (cur)
      ST_RUN: begin
        if (do_flush) begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (do_stall) begin
          id_ex_flush = 1'b1;
        end else if (start_halt) begin
          if_id_en   = 1'b1;
          if_id_halt = 1'b1;
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        if_id_en   = 1'b1;
        if_id_halt = 1'b1;
      end
      ST_HALTED: halted = 1'b1;
      default: ;
    endcase
    // Reset must never present a halt request to IF/ID.
    if (!rst_n) if_id_halt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      case (cur)
        ST_RUN: begin
          if (start_halt) begin
            cur       <= ST_DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) cur <= ST_HALTED;
          else drain_cnt <= drain_cnt - DW'(1);
        end
        ST_HALTED: begin
          if (go) cur <= ST_RUN;
        end
        default: cur <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (cur != ST_HALTED) cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (do_stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (do_flush) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios, a rule-level reference model checked
// every falling edge, and a narrow-counter instance for the wrap case.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int DRAIN = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_w = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  id_rs = '0, id_rt = '0, ex_wreg = '0;
  logic        id_use_rs = 0, id_use_rt = 0, id_sys_exit = 0;
  logic        ex_mem_read = 0, ex_br_taken = 0, go = 0;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, if_id_halt, halted;
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt;
  logic [1:0]  state;

  logic [4:0]  z5 = '0;
  logic        z1 = 1'b0;
  logic        w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_flush, w_if_id_halt, w_halted;
  logic [3:0]  w_cyc, w_stall, w_flush;
  logic [1:0]  w_state;

  pipe_ctrl #(.CNT_W(32), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_sys_exit(id_sys_exit),
    .ex_mem_read(ex_mem_read), .ex_wreg(ex_wreg), .ex_br_taken(ex_br_taken), .go(go),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .if_id_halt(if_id_halt), .halted(halted), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .state(state)
  );

  pipe_ctrl #(.CNT_W(4), .DRAIN_CYCLES(DRAIN)) dut_w (
    .clk(clk), .rst_n(rst_w), .id_rs(z5), .id_rt(z5),
    .id_use_rs(z1), .id_use_rt(z1), .id_sys_exit(z1),
    .ex_mem_read(z1), .ex_wreg(z5), .ex_br_taken(z1), .go(z1),
    .pc_en(w_pc_en), .if_id_en(w_if_id_en), .if_id_flush(w_if_id_flush),
    .id_ex_flush(w_id_ex_flush), .if_id_halt(w_if_id_halt), .halted(w_halted),
    .cyc_cnt(w_cyc), .stall_cnt(w_stall), .flush_cnt(w_flush), .state(w_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: halted flag, cycles of drain still owed, and plain counts.
  bit          m_halted = 1'b0;
  int          m_left = 0;
  logic [31:0] m_cyc = '0, m_stall = '0, m_flush = '0;

  function automatic logic hazard();
    return ex_mem_read && ex_wreg != 0 &&
           ((id_use_rs && id_rs == ex_wreg) || (id_use_rt && id_rt == ex_wreg));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_halted = 1'b0; m_left = 0; m_cyc = '0; m_stall = '0; m_flush = '0;
    end else begin
      if (!m_halted) m_cyc = m_cyc + 1;
      if (m_halted) begin
        if (go) m_halted = 1'b0;
      end else if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) m_halted = 1'b1;
      end else if (ex_br_taken) m_flush = m_flush + 1;
      else if (hazard()) m_stall = m_stall + 1;
      else if (id_sys_exit) m_left = DRAIN;
    end
  end

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    logic e_pc, e_en, e_iff, e_idf, e_hlt, e_hd;
    logic [1:0] e_st;
    {e_pc, e_en, e_iff, e_idf, e_hlt, e_hd} = '0;
    if (m_halted) begin
      e_hd = 1; e_st = ST_HALTED;
    end else if (m_left > 0) begin
      e_en = 1; e_hlt = 1; e_st = ST_DRAIN;
    end else begin
      e_st = ST_RUN;
      if (ex_br_taken) {e_pc, e_en, e_iff, e_idf} = 4'hf;
      else if (hazard()) e_idf = 1;
      else if (id_sys_exit) begin e_en = 1; e_hlt = 1; end
      else begin e_pc = 1; e_en = 1; end
    end
    if (!rst_n) e_hlt = 0;
    check("pc_en", pc_en, e_pc);
    check("if_id_en", if_id_en, e_en);
    check("if_id_flush", if_id_flush, e_iff);
    check("id_ex_flush", id_ex_flush, e_idf);
    check("if_id_halt", if_id_halt, e_hlt);
    check("halted", halted, e_hd);
    check("state", state, e_st);
    check("cyc_cnt", cyc_cnt, m_cyc);
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_sys_exit = 0;
    ex_mem_read = 0; ex_wreg = 0; ex_br_taken = 0; go = 0;
  endtask

  task automatic set_load(input logic [4:0] wreg, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt);
    ex_mem_read = 1; ex_wreg = wreg; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
  endtask

  logic [31:0] cyc_snap;

  initial begin
    // reset with an exit syscall visible: halt request must stay low
    id_sys_exit = 1;
    tick(2);
    #1;
    check("rst_if_id_halt", if_id_halt, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_cyc", cyc_cnt, 32'd0);
    idle();
    rst_n = 1;
    tick(3);
    check("cyc_after_3", cyc_cnt, 32'd3);

    // load into r0: no stall
    set_load(5'd0, 5'd0, 1, 5'd0, 0);
    #1;
    check("r0_pc_en", pc_en, 1'b1);
    tick();
    idle();
    check("r0_stall_cnt", stall_cnt, 32'd0);

    // load-use on rs
    set_load(5'd8, 5'd8, 1, 5'd0, 0);
    #1;
    check("lu_pc_en", pc_en, 1'b0);
    check("lu_if_id_en", if_id_en, 1'b0);
    check("lu_id_ex_flush", id_ex_flush, 1'b1);
    tick();
    idle();
    #1;
    check("lu_stall_cnt", stall_cnt, 32'd1);
    check("lu_release", pc_en, 1'b1);

    // directed hazard table: rt match, unused rs match, rs/rt mismatch
    set_load(5'd5, 5'd1, 0, 5'd5, 1); tick();
    set_load(5'd9, 5'd9, 0, 5'd9, 0); tick();
    set_load(5'd7, 5'd6, 1, 5'd3, 1); tick();
    set_load(5'd31, 5'd2, 1, 5'd31, 1); tick();
    idle();
    check("table_stall_cnt", stall_cnt, 32'd3);

    // branch beats load-use and exit syscall
    set_load(5'd4, 5'd4, 1, 5'd0, 0);
    id_sys_exit = 1; ex_br_taken = 1;
    #1;
    check("br_if_id_flush", if_id_flush, 1'b1);
    check("br_id_ex_flush", id_ex_flush, 1'b1);
    check("br_pc_en", pc_en, 1'b1);
    check("br_if_id_halt", if_id_halt, 1'b0);
    tick();
    idle();
    check("br_flush_cnt", flush_cnt, 32'd1);
    check("br_stall_cnt", stall_cnt, 32'd3);
    check("br_state_run", state, ST_RUN);

    // exit syscall: three drain cycles then halt; go ignored while draining
    id_sys_exit = 1;
    #1;
    check("exit_pc_en", pc_en, 1'b0);
    check("exit_if_id_halt", if_id_halt, 1'b1);
    tick();
    idle();
    go = 1;
    check("drain_state", state, ST_DRAIN);
    tick();
    go = 0;
    tick();
    check("drain_still", halted, 1'b0);
    tick();
    check("halted_after_3", halted, 1'b1);
    check("halted_pc_en", pc_en, 1'b0);
    cyc_snap = cyc_cnt;
    tick(3);
    check("cyc_frozen", cyc_cnt, cyc_snap);
    go = 1;
    tick();
    go = 0;
    check("go_state", state, ST_RUN);
    check("go_pc_en", pc_en, 1'b1);

    // reset while halted
    id_sys_exit = 1; tick(); idle(); tick(DRAIN);
    check("halted_again", halted, 1'b1);
    #2 rst_n = 0;
    #1;
    check("rst_halt_halted", halted, 1'b0);
    check("rst_halt_cyc", cyc_cnt, 32'd0);
    tick();
    rst_n = 1;
    tick(2);

    // reset mid-drain, asynchronous to clk
    id_sys_exit = 1; tick(); idle(); tick();
    check("mid_drain", state, ST_DRAIN);
    #2 rst_n = 0;
    #1;
    check("async_state", state, ST_RUN);
    check("async_if_id_halt", if_id_halt, 1'b0);
    check("async_cyc", cyc_cnt, 32'd0);
    check("async_stall", stall_cnt, 32'd0);
    check("async_flush", flush_cnt, 32'd0);
    tick();
    rst_n = 1;
    tick(4);
    check("post_rst_cyc", cyc_cnt, 32'd4);

    // 4-bit counter wrap
    rst_w = 1;
    tick(15);
    check("wrap_allones", w_cyc, 4'hf);
    tick();
    check("wrap_zero", w_cyc, 4'h0);
    check("wrap_stall", w_stall, 4'h0);
    check("wrap_flush", w_flush, 4'h0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
